// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single 8-bit SDRAM controller port between the buffered ioctl
// write stream and the CPU SRAM-style bus, alternating owners under contention.
module sdram_port_arbiter #(
    parameter int AW         = 23,
    parameter int FIFO_DEPTH = 4,
    parameter int GUARD      = 2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    output logic          ioctl_full,
    output logic          ioctl_ovf,
    input  logic          cpu_rd_n,
    input  logic          cpu_wr_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_d,
    output logic [7:0]    cpu_q,
    output logic          cpu_wait,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic          mem_ready,
    output logic          grant
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int HW = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(GUARD > 0 ? GUARD - 1 : 0);

    typedef enum logic [1:0] {IDLE, CMD, HOLD, WAIT} state_t;
    state_t state, state_nx;

    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nx;
    logic [HW-1:0] hold_cnt;
    logic          dl_d, cpu_done, last_owner, op_wr;
    logic          fifo_pend, cpu_req, cpu_pend, start, pick_io;
    logic          pop, push, drop, done_evt;

    always_comb begin
        fifo_pend = (count != '0);
        cpu_req   = !cpu_rd_n || !cpu_wr_n;
        cpu_pend  = cpu_req && !cpu_done;
        start     = (state == IDLE) && mem_ready && (fifo_pend || cpu_pend);
        // last_owner: 1 = ioctl; the other source wins a tie
        pick_io   = fifo_pend && (!cpu_pend || !last_owner);
        pop       = start && pick_io;
        push      = ioctl_wr && ((count != DEPTH_C) || pop);
        drop      = ioctl_wr && !push;
        done_evt  = (state == WAIT) && mem_ready;
        count_nx  = count + CW'(push) - CW'(pop);
    end

    assign cpu_wait = cpu_pend;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CMD;
            CMD:     state_nx = (GUARD == 0) ? WAIT : HOLD;
            HOLD:    if (hold_cnt == HOLD_LAST) state_nx = WAIT;
            WAIT:    if (mem_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        mem_rd = 1'b0;
        if (state == CMD) begin
            mem_we = op_wr;
            mem_rd = !op_wr;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ioctl_addr;
            fifo_data[wr_ptr] <= ioctl_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_full <= 1'b0;
            ioctl_ovf  <= 1'b0;
            dl_d       <= 1'b0;
            cpu_done   <= 1'b0;
            cpu_q      <= '0;
            last_owner <= 1'b0;
            grant      <= 1'b0;
            op_wr      <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            hold_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count      <= count_nx;
            ioctl_full <= (count_nx == DEPTH_C);
            dl_d       <= ioctl_download;
            if (drop)                          ioctl_ovf <= 1'b1;
            else if (ioctl_download && !dl_d)  ioctl_ovf <= 1'b0;

            // Operands are captured here so later CPU bus changes cannot disturb the access
            if (start) begin
                grant <= pick_io;
                if (pick_io) begin
                    mem_addr <= fifo_addr[rd_ptr];
                    mem_din  <= fifo_data[rd_ptr];
                    op_wr    <= 1'b1;
                end else begin
                    mem_addr <= cpu_addr;
                    mem_din  <= cpu_d;
                    op_wr    <= !cpu_wr_n;
                end
            end

            hold_cnt <= (state == HOLD) ? hold_cnt + HW'(1) : '0;

            if (done_evt) begin
                last_owner <= grant;
                if (!grant && !op_wr) cpu_q <= mem_dout;
            end
            if (done_evt && !grant) cpu_done <= 1'b1;
            else if (!cpu_req)      cpu_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus a random
// phase, all checked cycle by cycle against a transaction-level reference model.
module tb_sdram_port_arbiter;
    localparam int AW = 23;
    localparam int D  = 4;
    localparam int G  = 2;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_data = '0;
    logic          ioctl_full, ioctl_ovf;
    logic          cpu_rd_n = 1'b1;
    logic          cpu_wr_n = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_d = '0;
    logic [7:0]    cpu_q;
    logic          cpu_wait;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout = '0;
    logic          mem_we, mem_rd;
    logic          mem_ready = 1'b1;
    logic          grant;

    sdram_port_arbiter #(.AW(AW), .FIFO_DEPTH(D), .GUARD(G)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_full(ioctl_full), .ioctl_ovf(ioctl_ovf),
        .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_addr(cpu_addr),
        .cpu_d(cpu_d), .cpu_q(cpu_q), .cpu_wait(cpu_wait),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_ready(mem_ready), .grant(grant)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, access progress as a cycle count since grant
    typedef struct { logic [AW-1:0] addr; logic [7:0] data; } ent_t;
    typedef struct { bit io; bit wr; logic [AW-1:0] addr; logic [7:0] din; int cyc; } cmd_t;
    ent_t          q_m[$];
    cmd_t          log_q[$];
    bit            ovf_m, grant_m, last_m, done_m, dl_prev, cur_io, cur_wr;
    logic [7:0]    cpu_q_m, cur_din;
    logic [AW-1:0] cur_addr;
    int            busy_m, cyc, last_low;
    bit            last_wait, cmd_flag;

    // Controller stand-in: after each command, mem_ready drops for a chosen latency
    int         busy_cnt = 0, stall_next = 0, lat_max = 0;
    bit         ready_force_low = 1'b0, dout_fixed_en = 1'b1;
    logic [7:0] dout_fixed = 8'hA5;

    function automatic bit cpu_req_m();
        return !cpu_rd_n || !cpu_wr_n;
    endfunction

    always @(posedge clk_sys) begin
        #2;
        if (cmd_flag) begin
            busy_cnt = (stall_next > 0) ? stall_next : $urandom_range(0, lat_max);
            stall_next = 0;
            cmd_flag = 1'b0;
        end
        if (busy_cnt > 0) begin
            mem_ready = 1'b0;
            busy_cnt--;
        end else begin
            mem_ready = !ready_force_low;
        end
        mem_dout = dout_fixed_en ? dout_fixed : 8'($urandom);
    end

    always @(negedge clk_sys) begin : monitor
        bit   pend, pop, drop, fin;
        int   pre;
        ent_t e;
        cyc++;
        last_wait = cpu_wait;
        if (!mem_ready) last_low = cyc;
        if (mem_we || mem_rd) begin
            log_q.push_back('{grant, mem_we, mem_addr, mem_din, cyc});
            cmd_flag = 1'b1;
        end
        if (!reset_n) begin
            q_m.delete();
            ovf_m = 0; grant_m = 0; last_m = 0; done_m = 0; dl_prev = 0;
            cpu_q_m = '0; busy_m = 0;
        end else begin
            pend = cpu_req_m() && !done_m;
            check("cpu_wait", cpu_wait, pend);
            check("ioctl_full", ioctl_full, q_m.size() == D);
            check("ioctl_ovf", ioctl_ovf, ovf_m);
            check("grant", grant, grant_m);
            check("cpu_q", cpu_q, cpu_q_m);
            check("mem_we", mem_we, busy_m == 1 && cur_wr);
            check("mem_rd", mem_rd, busy_m == 1 && !cur_wr);
            if (busy_m > 0) begin
                check("mem_addr", mem_addr, cur_addr);
                check("mem_din", mem_din, cur_din);
            end
            pre = q_m.size();
            pop = 0; fin = 0; drop = 0;
            if (busy_m == 0) begin
                if (mem_ready && (pre > 0 || pend)) begin
                    cur_io = (pre > 0) && (!pend || !last_m);
                    if (cur_io) begin
                        e = q_m.pop_front();
                        cur_addr = e.addr; cur_din = e.data; cur_wr = 1; pop = 1;
                    end else begin
                        cur_addr = cpu_addr; cur_din = cpu_d; cur_wr = !cpu_wr_n;
                    end
                    grant_m = cur_io;
                    busy_m = 1;
                end
            end else if (busy_m >= G + 2) begin
                if (mem_ready) begin
                    fin = 1;
                    busy_m = 0;
                    last_m = cur_io;
                    if (!cur_io && !cur_wr) cpu_q_m = mem_dout;
                end
            end else begin
                busy_m++;
            end
            if (fin && !cur_io) done_m = 1;
            else if (!cpu_req_m()) done_m = 0;
            if (ioctl_wr) begin
                if (pre < D || pop) q_m.push_back('{ioctl_addr, ioctl_data});
                else drop = 1;
            end
            if (drop) ovf_m = 1;
            else if (ioctl_download && !dl_prev) ovf_m = 0;
            dl_prev = ioctl_download;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_quiet(input string tag, input int maxc);
        int n = 0;
        while ((busy_m != 0 || q_m.size() != 0 || (cpu_req_m() && !done_m)) && n < maxc) begin
            tick();
            n++;
        end
        check(tag, n < maxc, 1'b1);
    endtask

    task automatic count_wait(input int maxc, output int nw);
        nw = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk_sys);
            if (cpu_wait) nw++;
            else break;
        end
    endtask

    initial begin
        int nw, k;
        cmd_t c;
        repeat (3) tick();
        check("rst_grant", grant, 1'b0);
        check("rst_full", ioctl_full, 1'b0);
        check("rst_ovf", ioctl_ovf, 1'b0);
        check("rst_cpu_q", cpu_q, 8'h00);
        check("rst_cmd", {mem_we, mem_rd}, 2'b00);
        reset_n = 1'b1;
        repeat (2) tick();

        // CPU read, minimum latency, held strobe must not re-issue
        log_q.delete();
        cpu_addr = 23'h001234; cpu_rd_n = 1'b0;
        count_wait(60, nw);
        check("t1_wait_cycles", nw, 5);
        check("t1_cpu_q", cpu_q, 8'hA5);
        repeat (6) tick();
        check("t1_ncmd", log_q.size(), 1);
        c = log_q[0];
        check("t1_addr", c.addr, 23'h001234);
        check("t1_is_rd", c.wr, 1'b0);
        cpu_rd_n = 1'b1;
        repeat (2) tick();

        // CPU write contending with three FIFO entries; last owner was CPU
        log_q.delete();
        ready_force_low = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = AW'(32'h100 + i); ioctl_data = 8'(8'h20 + i);
            tick();
        end
        ioctl_wr = 1'b0;
        cpu_addr = 23'h7FFFFF; cpu_d = 8'h55; cpu_wr_n = 1'b0;
        tick();
        ready_force_low = 1'b0;
        wait_quiet("t3_timeout", 200);
        cpu_wr_n = 1'b1;
        tick();
        check("t3_ncmd", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("t3_grant_seq", {log_q[0].io, log_q[1].io, log_q[2].io, log_q[3].io}, 4'b1011);
            check("t3_cpu_addr", log_q[1].addr, 23'h7FFFFF);
            check("t3_cpu_din", log_q[1].din, 8'h55);
            check("t3_cpu_we", log_q[1].wr, 1'b1);
            check("t3_io_order", {log_q[0].addr[3:0], log_q[2].addr[3:0], log_q[3].addr[3:0]}, 12'h012);
        end

        // Fill the FIFO while the controller is busy, overflow, drain, clear
        log_q.delete();
        ioctl_download = 1'b1;
        ready_force_low = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = AW'(i); ioctl_data = 8'(8'h10 + i);
            tick();
        end
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        check("t2_full", ioctl_full, 1'b1);
        check("t2_ovf", ioctl_ovf, 1'b1);
        tick();
        ready_force_low = 1'b0;
        ioctl_download = 1'b0;
        wait_quiet("t2_timeout", 200);
        check("t2_nwe", log_q.size(), 4);
        for (int i = 0; i < log_q.size() && i < 4; i++) begin
            check("t2_we", {log_q[i].io, log_q[i].wr}, 2'b11);
            check("t2_addr", log_q[i].addr, AW'(i));
            check("t2_data", log_q[i].din, 8'(8'h10 + i));
        end
        check("t2_ovf_sticky", ioctl_ovf, 1'b1);
        ioctl_download = 1'b1;
        tick();
        tick();
        check("t2_ovf_clr", ioctl_ovf, 1'b0);

        // Controller stays busy 10 cycles after the command
        log_q.delete();
        stall_next = 10;
        cpu_addr = 23'h02468A; cpu_rd_n = 1'b0;
        count_wait(80, nw);
        check("t4_wait_cycles", nw, 13);
        check("t4_ncmd", log_q.size(), 1);
        cpu_rd_n = 1'b1;
        repeat (2) tick();

        // Both strobes low: a single write
        log_q.delete();
        cpu_addr = 23'h000555; cpu_d = 8'h3C; cpu_rd_n = 1'b0; cpu_wr_n = 1'b0;
        wait_quiet("t5_timeout", 100);
        repeat (3) tick();
        check("t5_ncmd", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check("t5_we", log_q[0].wr, 1'b1);
            check("t5_din", log_q[0].din, 8'h3C);
        end
        cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        repeat (2) tick();

        // Reset in HOLD with FIFO entries queued; controller still busy afterwards
        stall_next = 8;
        cpu_addr = 23'h0ABCDE; cpu_rd_n = 1'b0;
        ioctl_wr = 1'b1; ioctl_addr = 23'h11; ioctl_data = 8'h77;
        tick();
        ioctl_addr = 23'h12;
        tick();
        ioctl_wr = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_cmd", {mem_we, mem_rd}, 2'b00);
        check("t6_rst_grant", grant, 1'b0);
        check("t6_rst_cpu_q", cpu_q, 8'h00);
        check("t6_rst_addr", mem_addr, '0);
        check("t6_rst_din", mem_din, 8'h00);
        check("t6_rst_flags", {ioctl_full, ioctl_ovf}, 2'b00);
        tick();
        tick();
        reset_n = 1'b1;
        log_q.delete();
        wait_quiet("t6_timeout", 100);
        cpu_rd_n = 1'b1;
        repeat (2) tick();
        check("t6_ncmd", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check("t6_rd", {log_q[0].io, log_q[0].wr}, 2'b00);
            check("t6_after_ready", (log_q[0].cyc - last_low) >= 2, 1'b1);
        end

        // Random traffic under random controller latency
        lat_max = 5;
        dout_fixed_en = 1'b0;
        k = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            ioctl_wr = ($urandom_range(0, 4) == 0);
            ioctl_addr = AW'($urandom);
            ioctl_data = 8'($urandom);
            if ($urandom_range(0, 99) == 0) ioctl_download = !ioctl_download;
            cpu_addr = AW'($urandom);
            cpu_d = 8'($urandom);
            if (!cpu_rd_n || !cpu_wr_n) begin
                if (!last_wait) begin
                    cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(0, 3);
                cpu_rd_n = (k == 2);
                cpu_wr_n = (k < 2);
            end
        end
        tick();
        ioctl_wr = 1'b0;
        wait_quiet("rand_drain", 500);
        cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
